// File: rtl/matrix_pkg.sv
// Shared sizing, state encoding and row-major address helper for the matrix multiplier.
package matrix_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 3;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = $clog2(N * (2**DATA_W - 1) * (2**DATA_W - 1) + 1);
  localparam int IDX_W  = $clog2(N);

  // Prefixed so the DONE state cannot collide with the DONE port
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] rc_addr(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/matrix_mult_fsmd_mac.sv
// Multiply-accumulate register: unsigned DATA_W x DATA_W product added into an ACC_W accumulator.
module mac_unit #(
  parameter int DATA_W = 3,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  function automatic logic [ACC_W-1:0] widen_product(input logic [DATA_W-1:0] x,
                                                     input logic [DATA_W-1:0] y);
    logic [2*DATA_W-1:0] p;
    p = x * y;
    return ACC_W'(p);
  endfunction

  // clr restarts the sum with the first product of a new element
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clr ? '0 : acc) + widen_product(a, b);
    end
  end

endmodule

// File: rtl/matrix_mult_fsmd.sv
// FSMD computing C = A x B over row-major RAMs; one C element written every N+2 cycles.
import matrix_pkg::*;

module matrix_mult_fsmd (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] A_DATA,
  input  logic [DATA_W-1:0] B_DATA,
  output logic [ADDR_W-1:0] ADDRESS_A,
  output logic [ADDR_W-1:0] ADDRESS_B,
  output logic              Write_EN_A,
  output logic [ADDR_W-1:0] C_ADDR,
  output logic [ACC_W-1:0]  C_DATA,
  output logic              C_WE,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] i, j, k;
  logic [IDX_W-1:0] i_nxt, j_nxt, k_nxt;
  logic             vld_p1;
  logic [IDX_W-1:0] k_p1;
  logic [ACC_W-1:0] acc;

  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = ST_CALC;
          i_nxt     = '0;
          j_nxt     = '0;
          k_nxt     = '0;
        end
      end
      ST_CALC: begin
        if (k == LAST) begin
          state_nxt = ST_DRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + IDX_W'(1);
        end
      end
      ST_DRAIN: state_nxt = ST_WRITE;
      ST_WRITE: begin
        k_nxt = '0;
        if (j == LAST) begin
          j_nxt = '0;
          i_nxt = (i == LAST) ? '0 : i + IDX_W'(1);
        end else begin
          j_nxt = j + IDX_W'(1);
        end
        state_nxt = (i == LAST && j == LAST) ? ST_DONE : ST_CALC;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: addresses are registered from next-cycle indices so step k is on the bus during CALC(k)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      vld_p1    <= 1'b0;
      k_p1      <= '0;
      ADDRESS_A <= '0;
      ADDRESS_B <= '0;
    end else begin
      state  <= state_nxt;
      i      <= i_nxt;
      j      <= j_nxt;
      k      <= k_nxt;
      vld_p1 <= (state == ST_CALC);
      k_p1   <= k;
      if (state_nxt == ST_CALC) begin
        ADDRESS_A <= rc_addr(i_nxt, k_nxt);
        ADDRESS_B <= rc_addr(k_nxt, j_nxt);
      end else begin
        ADDRESS_A <= '0;
        ADDRESS_B <= '0;
      end
    end
  end

  // Stage p1: RAM data for step k_p1 is valid; accumulate it
  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (CLK),
    .rst (RST),
    .en  (vld_p1),
    .clr (k_p1 == '0),
    .a   (A_DATA),
    .b   (B_DATA),
    .acc (acc)
  );

  assign Write_EN_A = 1'b0;
  assign C_WE       = (state == ST_WRITE);
  assign C_ADDR     = C_WE ? rc_addr(i, j) : '0;
  assign C_DATA     = C_WE ? acc : '0;
  assign BUSY       = (state == ST_CALC) || (state == ST_DRAIN) || (state == ST_WRITE);
  assign DONE       = (state == ST_DONE);

endmodule

// File: tb/tb_matrix_mult_fsmd.sv
// Scoreboard bench for matrix_mult_fsmd with behavioural A/B RAMs.
module tb_matrix_mult_fsmd;
  import matrix_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [DATA_W-1:0] a_data, b_data;
  logic [ADDR_W-1:0] address_a, address_b, c_addr;
  logic              write_en_a, c_we, busy, done;
  logic [ACC_W-1:0]  c_data;

  always #5 clk = ~clk;

  matrix_mult_fsmd dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .A_DATA     (a_data),
    .B_DATA     (b_data),
    .ADDRESS_A  (address_a),
    .ADDRESS_B  (address_b),
    .Write_EN_A (write_en_a),
    .C_ADDR     (c_addr),
    .C_DATA     (c_data),
    .C_WE       (c_we),
    .BUSY       (busy),
    .DONE       (done)
  );

  logic [DATA_W-1:0] mem_a [N*N];
  logic [DATA_W-1:0] mem_b [N*N];

  always @(posedge clk) begin
    a_data <= mem_a[address_a];
    b_data <= mem_b[address_b];
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ACC_W-1:0]  data;
  } c_exp_t;

  c_exp_t sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"},   32'(busy), 0);
    check_val({tag, "_done"},   32'(done), 0);
    check_val({tag, "_c_we"},   32'(c_we), 0);
    check_val({tag, "_c_addr"}, 32'(c_addr), 0);
    check_val({tag, "_c_data"}, 32'(c_data), 0);
    check_val({tag, "_addr_a"}, 32'(address_a), 0);
    check_val({tag, "_addr_b"}, 32'(address_b), 0);
    check_val({tag, "_we_a"},   32'(write_en_a), 0);
  endtask

  task automatic push_expected();
    for (int m = 0; m < N*N; m++) begin
      int     row, col, sum;
      c_exp_t e;
      row = m / N;
      col = m % N;
      sum = 0;
      for (int kk = 0; kk < N; kk++)
        sum += int'(mem_a[row*N + kk]) * int'(mem_b[kk*N + col]);
      e.addr = ADDR_W'(m);
      e.data = ACC_W'(sum);
      sb.push_back(e);
    end
  endtask

  // abort_at < 0 runs to completion; otherwise RST is pulsed after cycle abort_at
  task automatic run_matmul(input bit extra_start, input int abort_at);
    int                n_we, n_done, done_t, m, s;
    c_exp_t            e;
    logic [ADDR_W-1:0] ea, eb;
    n_we   = 0;
    n_done = 0;
    done_t = -1;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 0; t <= 100; t++) begin
      @(negedge clk);
      if (abort_at >= 0 && t == abort_at + 1) begin
        rst = 1'b0;
        check_idle_outputs("abort");
        break;
      end
      if (c_we) begin
        n_we++;
        if (sb.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check_val("c_addr", 32'(c_addr), 32'(e.addr));
          check_val("c_data", 32'(c_data), 32'(e.data));
        end
      end
      if (done) begin
        n_done++;
        if (done_t < 0) done_t = t;
      end
      if (t == 0)  check_val("busy_rise", 32'(busy), 1);
      if (t == 95) check_val("done_early", 32'(done), 0);
      if (t == 96) check_val("busy_at_done", 32'(busy), 0);
      if (t < 96) begin
        m = t / (N + 2);
        s = t % (N + 2);
        if (s < N) begin
          ea = ADDR_W'((m / N) * N + s);
          eb = ADDR_W'(s * N + (m % N));
        end else begin
          ea = '0;
          eb = '0;
        end
        check_val("addr_a", 32'(address_a), 32'(ea));
        check_val("addr_b", 32'(address_b), 32'(eb));
      end
      start = extra_start && (t == 10 || t == 50);
      if (t == abort_at) rst = 1'b1;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      check_val("abort_writes", 32'(n_we), 32'(abort_at / (N + 2)));
      sb.delete();
      @(negedge clk);
      check_idle_outputs("post_abort");
    end else begin
      check_val("done_cycle", 32'(done_t), 96);
      check_val("done_pulses", 32'(n_done), 1);
      check_val("c_we_count", 32'(n_we), 16);
      check_val("sb_left", 32'(sb.size()), 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
    end
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // identity x (1..16 mod 8) reproduces B
    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = ((x / N) == (x % N)) ? DATA_W'(1) : DATA_W'(0);
      mem_b[x] = DATA_W'((x + 1) % 8);
    end
    run_matmul(1'b0, -1);

    // full-scale operands: every element 4*49 = 196
    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = DATA_W'(7);
      mem_b[x] = DATA_W'(7);
    end
    run_matmul(1'b0, -1);

    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = DATA_W'($urandom_range(0, 7));
      mem_b[x] = DATA_W'($urandom_range(0, 7));
    end
    run_matmul(1'b0, -1);
    run_matmul(1'b1, -1);

    run_matmul(1'b0, 32);
    run_matmul(1'b0, -1);

    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
    end
    run_matmul(1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
